// File: rtl/regfile_write_arbiter.sv
// Register file write-port owner: round-robin arbitration between the ALU
// writeback (A) and the load writeback (B), a one-cycle registered write
// stage, and a per-register pending scoreboard that decode uses for hazards.
module regfile_write_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                A_Valid,
  input  logic [ADDR_W-1:0]   A_Reg,
  input  logic [DATA_W-1:0]   A_Data,
  output logic                A_Ready,
  input  logic                B_Valid,
  input  logic [ADDR_W-1:0]   B_Reg,
  input  logic [DATA_W-1:0]   B_Data,
  output logic                B_Ready,
  input  logic                Reserve_Valid,
  input  logic [ADDR_W-1:0]   Reserve_Reg,
  output logic                Reserve_Ready,
  output logic [NUM_REGS-1:0] Pending,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   Write_Reg,
  output logic [DATA_W-1:0]   Write_Data
);

  // Round-robin pointer: names the side that wins when both requesters are valid.
  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  ptr_e                ptr_q, ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                grant_a, grant_b;
  logic                rsv_ok;

  // Grant selection, pointer update and write-stage next state.
  always_comb begin
    grant_a   = A_Valid && (!B_Valid || (ptr_q == PTR_A));
    grant_b   = B_Valid && (!A_Valid || (ptr_q == PTR_B));
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (grant_a) begin
      ptr_d     = PTR_B;
      wr_en_d   = 1'b1;
      wr_reg_d  = A_Reg;
      wr_data_d = A_Data;
    end else if (grant_b) begin
      ptr_d     = PTR_A;
      wr_en_d   = 1'b1;
      wr_reg_d  = B_Reg;
      wr_data_d = B_Data;
    end
  end

  // Scoreboard: clear on the write in flight, then set on an accepted reserve
  // so that a same-register reserve and clear leaves the bit set.
  always_comb begin
    rsv_ok = !pend_q[Reserve_Reg] || (wr_en_q && (wr_reg_q == Reserve_Reg));
    pend_d = pend_q;
    if (wr_en_q) begin
      pend_d[wr_reg_q] = 1'b0;
    end
    if (Reserve_Valid && rsv_ok) begin
      pend_d[Reserve_Reg] = 1'b1;
    end
  end

  // State registers; reset drops any in-flight write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= PTR_A;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      pend_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      pend_q    <= pend_d;
    end
  end

  assign A_Ready       = grant_a;
  assign B_Ready       = grant_b;
  assign Reserve_Ready = rsv_ok;
  assign Pending       = pend_q;
  assign RegWrite      = wr_en_q;
  assign Write_Reg     = wr_reg_q;
  assign Write_Data    = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level reference model with a
// write scoreboard drained by an independent monitor.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        A_Valid = 1'b0, B_Valid = 1'b0, Reserve_Valid = 1'b0;
  logic [3:0]  A_Reg = '0, B_Reg = '0, Reserve_Reg = '0;
  logic [15:0] A_Data = '0, B_Data = '0;
  logic        A_Ready, B_Ready, Reserve_Ready, RegWrite;
  logic [15:0] Pending, Write_Data;
  logic [3:0]  Write_Reg;

  regfile_write_arbiter #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .A_Valid(A_Valid), .A_Reg(A_Reg), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Reg(B_Reg), .B_Data(B_Data), .B_Ready(B_Ready),
    .Reserve_Valid(Reserve_Valid), .Reserve_Reg(Reserve_Reg),
    .Reserve_Ready(Reserve_Ready), .Pending(Pending),
    .RegWrite(RegWrite), .Write_Reg(Write_Reg), .Write_Data(Write_Data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  r;
    logic [15:0] d;
  } wr_t;
  wr_t exp_q[$];

  // Reference model: set of registers awaiting a write, the write that lands
  // this cycle, and which side won the most recent grant.
  logic [15:0] m_pend;
  bit          m_wv;
  logic [3:0]  m_wreg;
  bit          m_last_b;
  bit          a_granted, b_granted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", name, act, req, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_pend   = '0;
    m_wv     = 0;
    m_wreg   = '0;
    m_last_b = 1;  // so that A wins the first contention
    exp_q.delete();
  endtask

  // Called at posedge+1 with inputs set; checks this cycle and advances the model.
  task automatic run_cycle();
    bit          ga, gb, rr;
    logic [15:0] np;
    bit          nwv;
    logic [3:0]  nwreg;
    #1;
    ga = A_Valid && (!B_Valid || m_last_b);
    gb = B_Valid && !ga;
    rr = !m_pend[Reserve_Reg] || (m_wv && m_wreg == Reserve_Reg);
    chk("A_Ready", {31'b0, A_Ready}, {31'b0, ga});
    chk("B_Ready", {31'b0, B_Ready}, {31'b0, gb});
    chk("Reserve_Ready", {31'b0, Reserve_Ready}, {31'b0, rr});
    chk("Pending", {16'b0, Pending}, {16'b0, m_pend});
    np = m_pend;
    if (m_wv) np[m_wreg] = 1'b0;
    if (Reserve_Valid && rr) np[Reserve_Reg] = 1'b1;
    nwv = 0;
    nwreg = m_wreg;
    if (ga) begin
      exp_q.push_back('{cyc: cyc, r: A_Reg, d: A_Data});
      nwv = 1; nwreg = A_Reg; m_last_b = 0;
    end else if (gb) begin
      exp_q.push_back('{cyc: cyc, r: B_Reg, d: B_Data});
      nwv = 1; nwreg = B_Reg; m_last_b = 1;
    end
    a_granted = ga;
    b_granted = gb;
    @(posedge clk);
    #1;
    m_pend = np;
    m_wv   = nwv;
    m_wreg = nwreg;
  endtask

  task automatic idle_inputs();
    A_Valid = 0; B_Valid = 0; Reserve_Valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Monitor: every cycle the write port must show exactly the write granted
  // in the previous cycle, in grant order.
  always @(negedge clk) begin
    if (!rst) begin
      bit  exp_w;
      wr_t e;
      exp_w = (exp_q.size() > 0) && (exp_q[0].cyc == cyc - 1);
      chk("RegWrite", {31'b0, RegWrite}, {31'b0, exp_w});
      if (exp_w) begin
        e = exp_q.pop_front();
        if (RegWrite) begin
          chk("Write_Reg", {28'b0, Write_Reg}, {28'b0, e.r});
          chk("Write_Data", {16'b0, Write_Data}, {16'b0, e.d});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // Reset then idle
    chk("reset_Write_Reg", {28'b0, Write_Reg}, 32'h0);
    chk("reset_Write_Data", {16'b0, Write_Data}, 32'h0);
    Reserve_Reg = 4'd5;
    run_cycle();
    run_cycle();

    // Single write to a reserved register
    Reserve_Valid = 1; Reserve_Reg = 4'd3;
    run_cycle();
    Reserve_Valid = 0;
    A_Valid = 1; A_Reg = 4'd3; A_Data = 16'h1234;
    run_cycle();
    chk("single_A_granted", {31'b0, a_granted}, 32'h1);
    A_Valid = 0;
    run_cycle();
    run_cycle();

    // Contention from reset: A first, then B
    do_reset();
    A_Valid = 1; A_Reg = 4'd1; A_Data = 16'h00AA;
    B_Valid = 1; B_Reg = 4'd2; B_Data = 16'h00BB;
    run_cycle();
    A_Valid = 0;
    run_cycle();
    B_Valid = 0;
    run_cycle();
    run_cycle();

    // Round-robin fairness: both continuously valid for six cycles
    A_Valid = 1; B_Valid = 1;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      chk("rr_alternate", {31'b0, a_granted}, (i % 2 == 0) ? 32'h1 : 32'h0);
      if (a_granted) begin A_Reg = 4'($urandom); A_Data = 16'($urandom); end
      if (b_granted) begin B_Reg = 4'($urandom); B_Data = 16'($urandom); end
    end
    idle_inputs();
    run_cycle();

    // WAW stall and same-cycle reserve/clear
    do_reset();
    Reserve_Valid = 1; Reserve_Reg = 4'd7;
    run_cycle();
    A_Valid = 1; A_Reg = 4'd7; A_Data = 16'h7777;
    run_cycle();                      // second reserve must be refused
    A_Valid = 0;
    run_cycle();                      // write to R7 lands; reserve again accepted
    Reserve_Valid = 0;
    run_cycle();                      // Pending[7] must still be set
    chk("waw_pending7", {31'b0, Pending[7]}, 32'h1);

    // Reset in the middle of a registered write
    B_Valid = 1; B_Reg = 4'd9; B_Data = 16'hBEEF;
    run_cycle();
    B_Valid = 0;
    #1;
    chk("midwrite_RegWrite_before", {31'b0, RegWrite}, 32'h1);
    rst = 1;
    model_reset();
    #1;
    chk("midwrite_RegWrite_async", {31'b0, RegWrite}, 32'h0);
    chk("midwrite_Pending", {16'b0, Pending}, 32'h0);
    rst = 0;
    @(posedge clk);
    #1;
    A_Valid = 1; A_Reg = 4'd4; A_Data = 16'hA0A0;
    B_Valid = 1; B_Reg = 4'd5; B_Data = 16'hB0B0;
    run_cycle();
    chk("post_reset_A_first", {31'b0, a_granted}, 32'h1);
    idle_inputs();
    run_cycle();

    // Random traffic honouring the hold-until-ready handshake
    a_granted = 0; b_granted = 0;
    for (int i = 0; i < 3000; i++) begin
      if (a_granted || !A_Valid) begin
        A_Valid = ($urandom_range(0, 9) < 6);
        A_Reg   = 4'($urandom);
        A_Data  = 16'($urandom);
      end
      if (b_granted || !B_Valid) begin
        B_Valid = ($urandom_range(0, 9) < 6);
        B_Reg   = 4'($urandom);
        B_Data  = 16'($urandom);
      end
      Reserve_Valid = ($urandom_range(0, 1) == 1);
      Reserve_Reg   = 4'($urandom);
      run_cycle();
    end

    idle_inputs();
    repeat (3) run_cycle();
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 16x16 register file (`RegWrite`, `Write_Reg`, `Write_Data`).
- Shares that port between two writeback requesters using round-robin arbitration:
  - requester A is the ALU writeback;
  - requester B is the memory/load writeback.
- Keeps a per-register pending scoreboard so decode can stall on WAW and RAW hazards.
- Sits between the writeback sources and the register file; decode reads `Pending` and drives `Reserve`.

Parameters:
- NUM_REGS, 16, number of architectural registers; also the width of `Pending`.
- ADDR_W, 4, register address width.
- DATA_W, 16, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- A_Valid  in  1  requester A has a write pending.
- A_Reg  in  ADDR_W  requester A destination register.
- A_Data  in  DATA_W  requester A write data.
- A_Ready  out  1  requester A is granted this cycle.
- B_Valid  in  1  requester B has a write pending.
- B_Reg  in  ADDR_W  requester B destination register.
- B_Data  in  DATA_W  requester B write data.
- B_Ready  out  1  requester B is granted this cycle.
- Reserve_Valid  in  1  decode issues an instruction with a register destination.
- Reserve_Reg  in  ADDR_W  destination register being reserved.
- Reserve_Ready  out  1  the reservation is accepted this cycle.
- Pending  out  NUM_REGS  bit i = register i has an outstanding write.
- RegWrite  out  1  write enable to the register file.
- Write_Reg  out  ADDR_W  write address to the register file.
- Write_Data  out  DATA_W  write data to the register file.

Behaviour:
- Reset (asynchronous):
  - `RegWrite` = 0, `Write_Reg` = 0, `Write_Data` = 0, `Pending` = 0.
  - Round-robin pointer = A.
  - All `Ready` outputs follow combinationally from the reset state.
- Handshake:
  - A transfer occurs when Valid && Ready in the same cycle.
  - A requester holds Valid, Reg and Data stable until it sees Ready.
  - `A_Ready` and `B_Ready` are combinational, never both 1, and never 1 while the matching Valid is 0.
- Arbitration:
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the side the pointer names.
  - On every grant the pointer moves to the non-granted side.
  - A cycle with no grant leaves the pointer unchanged.
- Output stage:
  - Registered, latency 1: a grant in cycle N drives `RegWrite` = 1 with the granted Reg/Data during cycle N+1.
  - The register file captures the write at the end of cycle N+1.
  - Throughput is one write per cycle; back-to-back grants give back-to-back `RegWrite` pulses.
  - No grant in cycle N -> `RegWrite` = 0 in N+1; `Write_Reg`/`Write_Data` hold their previous values.
- Scoreboard:
  - On an accepted reserve, `Pending[Reserve_Reg]` is set at the clock edge.
  - A bit is cleared at the edge ending a cycle in which `RegWrite` = 1, for bit `Write_Reg`.
  - `Reserve_Ready` = !Pending[Reserve_Reg] || (RegWrite && Write_Reg == Reserve_Reg).
  - A reserve with `Reserve_Ready` = 0 is ignored; decode must stall and retry.
  - Reserve and clear on the same register in the same cycle: set wins, and the bit stays 1.
- Unreserved writes: a write to a register whose Pending bit is 0 is legal and performed; the clear is a no-op.
- Register 0 has no special treatment.
- Reset mid-operation:
  - An in-flight registered write is dropped: `RegWrite` goes to 0 immediately (asynchronous).
  - All Pending bits clear.

Test Plan:
- Reset then idle:
  - Check `RegWrite` = 0, `Pending` = 0x0000, `A_Ready` = `B_Ready` = 0.
  - Drive `Reserve_Reg` = 5 with `Reserve_Valid` = 0 -> `Reserve_Ready` = 1 and `Pending` stays 0x0000.
- Single write:
  - Reserve R3.
  - Next cycle, A_Valid with A_Reg = 3, A_Data = 0x1234.
  - Required: `A_Ready` = 1 that cycle.
  - One cycle later: `RegWrite` = 1, `Write_Reg` = 3, `Write_Data` = 0x1234.
  - After that edge, Pending[3] = 0.
- Contention:
  - A (R1, 0x00AA) and B (R2, 0x00BB) both valid from reset; each drops Valid after its grant.
  - Required: A granted first, B on the next cycle.
  - `RegWrite` on two consecutive cycles: R1/0x00AA, then R2/0x00BB.
- Round-robin fairness:
  - A and B both continuously valid for 6 cycles.
  - Required: grants A,B,A,B,A,B; the pointer alternates with no starvation.
- WAW stall and same-cycle reserve/clear:
  - Reserve R7; Pending[7] = 1.
  - Second reserve of R7 -> `Reserve_Ready` = 0 and it is ignored.
  - In the cycle `RegWrite` = 1 with `Write_Reg` = 7, reserve R7 again -> `Reserve_Ready` = 1 and Pending[7] remains 1 after the edge.
- Reset mid-write:
  - Grant B (R9, 0xBEEF), then assert rst during the `RegWrite` cycle.
  - Required: `RegWrite` drops to 0 asynchronously and `Pending` = 0x0000.
  - After rst releases with A and B both valid, A is granted.
